crc_stream_feeder: RTL and testbench
====================================

CRC_STREAM_FEEDER -- requirements
Module: crc_stream_feeder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameters SHALL be: DATA_BYTES, default 8, bytes per beat; CRC_WIDTH, default 32, CRC register width.
REQ-003 Ports SHALL be (name direction width meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- cfg_seed, cfg_poly, cfg_xor_out  in  CRC_WIDTH  initial value, polynomial, final XOR
- cfg_reflect_in, cfg_reflect_out  in  1  per-byte input reflection, output reflection
- s_valid, s_last  in  1  beat valid, last beat of frame
- s_ready  out  1  beat accepted when s_valid & s_ready
- s_data  in  DATA_BYTES*8  byte j = s_data[8j+:8], byte 0 first on wire
- s_keep  in  DATA_BYTES  valid-byte mask; honoured on the last beat only
- eng_data  out  DATA_BYTES*8  to engine data_in
- eng_crc_in, eng_poly  out  CRC_WIDTH  to engine crc_in and polynomial
- eng_enable, eng_reflect_in  out  1  to engine enable and reflect_in
- eng_reflect_out  out  1  tied 0
- eng_final_xor  out  CRC_WIDTH  tied 0
- eng_crc_out  in  CRC_WIDTH  engine registered result, 1-cycle latency
- res_valid  out  1  result valid; held until res_ready
- res_ready  in  1  result consumer ready
- res_crc  out  CRC_WIDTH  final CRC
- res_err  out  1  last-beat s_keep was non-contiguous

Function
REQ-004 States SHALL be IDLE, RUN, FLUSH, TAIL, RESULT.
REQ-005 s_ready SHALL be 1 in IDLE and RUN and 0 in all other states.
REQ-006 eng_crc_in SHALL be cfg_seed in IDLE and eng_crc_out in all other states, so the engine holds its value on non-enabled cycles.
REQ-007 cfg_* SHALL be latched on first-beat acceptance in IDLE; eng_poly and eng_reflect_in SHALL come from live cfg in IDLE and from the latched copy otherwise.
REQ-008 An accepted non-last beat SHALL assert eng_enable with eng_data = s_data in the same cycle; IDLE->RUN, RUN stays RUN; throughput is one beat per cycle.
REQ-009 An accepted last beat with all s_keep bits set SHALL assert eng_enable and go to FLUSH; FLUSH->RESULT after one cycle.
REQ-010 An accepted last beat with partial keep SHALL deassert eng_enable, latch the beat and k = count of contiguous ones from bit 0, and load acc = eng_crc_in; go to TAIL if k>0, else RESULT.
REQ-011 TAIL SHALL process one byte per cycle, bytes 0..k-1, in order: optional byte reflection, acc ^= byte<<(CRC_WIDTH-8), then 8 MSB-first shift/XOR-poly steps; TAIL->RESULT after k cycles.
REQ-012 On entry to RESULT, res_crc SHALL be registered as (cfg_reflect_out ? bit-reverse(x) : x) ^ cfg_xor_out, where x = eng_crc_out from FLUSH or acc from TAIL/k=0.
REQ-013 Latency from last-beat acceptance at cycle t to res_valid SHALL be: full beat t+2; k tail bytes t+k+1; k=0 t+1.
REQ-014 res_err SHALL be 1 if last-beat s_keep has any set bit above the first zero; CRC still covers the k contiguous bytes.
REQ-015 res_valid SHALL be 1 only in RESULT; RESULT->IDLE on res_ready; res_crc and res_err stay stable while res_valid & ~res_ready.
REQ-016 s_keep SHALL be ignored on non-last beats.

Reset
REQ-017 rst SHALL force IDLE, res_valid=0, res_crc=0, res_err=0, eng_enable=0, and acc=0; a frame in progress is discarded; the engine resets on its own.

Structure
REQ-018 A shared package crc_pkg SHALL hold the state enum, byte-reflect and bit-reverse functions, and the byte-step function crc_byte_step.
REQ-019 A single optional sub-module crc_tail_lane SHALL wrap the acc register and crc_byte_step.

Verification
REQ-020 CRC-32 check (poly 04C11DB7, seed FFFFFFFF, reflect in/out, xor FFFFFFFF): beat "12345678" + last beat "9" with keep 0x01 -> res_crc CBF43926, res_err 0, latency t+2.
REQ-021 CRC-32/MPEG-2 (same poly, seed FFFFFFFF, no reflect, xor 0): same bytes -> 0376E6E7.
REQ-022 16 bytes 0x00..0x0F as two full beats -> res_crc matches reference model, res_valid at t+2, s_ready=0 during FLUSH.
REQ-023 res_ready held 0 for 5 cycles -> res_valid and res_crc stable; s_ready=0 throughout; next frame accepted after handshake.
REQ-024 Last beat with keep 0x05 -> res_err 1, CRC over byte 0 only; keep 0x00 -> res_valid at t+1 with res_crc equal to the running CRC, finalised per REQ-012.
REQ-025 rst pulsed in TAIL -> IDLE next cycle, res_valid 0, s_ready 1; a following "123456789" frame -> CBF43926.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared definitions for the CRC stream feeder.
//
// Contents:
//   state_t          - feeder FSM states
//   CRC_MAX          - widest CRC the helper functions handle
//   reflect_byte     - reverse the bit order inside one byte
//   bit_reverse      - reverse the low 'width' bits of a value
//   crc_byte_step    - fold one byte into a CRC register, MSB-first
//   crc_finalize     - optional output reflection, then final XOR
//
// The functions work on CRC_MAX-bit vectors and take the real CRC width as
// an argument, so a module of any CRC_WIDTH in 8..CRC_MAX can share them by
// zero-extending its operands and truncating the result.
package crc_pkg;

  localparam int CRC_MAX = 64;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FLUSH,
    TAIL,
    RESULT
  } state_t;

  function automatic logic [7:0] reflect_byte(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

  function automatic logic [CRC_MAX-1:0] width_mask(input int width);
    logic [CRC_MAX-1:0] m;
    if (width >= CRC_MAX) m = '1;
    else                  m = (CRC_MAX'(1) << width) - CRC_MAX'(1);
    return m;
  endfunction

  function automatic logic [CRC_MAX-1:0] bit_reverse(input logic [CRC_MAX-1:0] x,
                                                     input int width);
    logic [CRC_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < CRC_MAX; i++) begin
      if (i < width) r[i] = x[width-1-i];
    end
    return r;
  endfunction

  // One byte of a non-reflected (MSB-first) CRC: the byte is XORed into the
  // top of the register, then eight shift / conditional-XOR steps follow.
  function automatic logic [CRC_MAX-1:0] crc_byte_step(input logic [CRC_MAX-1:0] crc,
                                                       input logic [7:0]         data,
                                                       input logic [CRC_MAX-1:0] poly,
                                                       input logic               reflect_in,
                                                       input int                 width);
    logic [CRC_MAX-1:0] c;
    logic [7:0]         d;
    d = reflect_in ? reflect_byte(data) : data;
    c = crc ^ ({{(CRC_MAX-8){1'b0}}, d} << (width - 8));
    for (int b = 0; b < 8; b++) begin
      // Bits shifted above the CRC width are junk; only bit width-1 is
      // looked at, and the mask below clears the rest.
      c = c[width-1] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c & width_mask(width);
  endfunction

  function automatic logic [CRC_MAX-1:0] crc_finalize(input logic [CRC_MAX-1:0] x,
                                                      input logic               reflect_out,
                                                      input logic [CRC_MAX-1:0] xor_out,
                                                      input int                 width);
    logic [CRC_MAX-1:0] r;
    r = reflect_out ? bit_reverse(x, width) : x;
    return (r ^ xor_out) & width_mask(width);
  endfunction

endpackage

// File: rtl/crc_tail_lane.sv
// Byte-serial CRC lane used for the partial last beat of a frame.
//
// Ports:
//   clk, rst     clock, async active-high reset (clears acc)
//   load         capture load_value into acc (running CRC at last-beat time)
//   load_value   CRC_WIDTH running CRC to start the tail from
//   step         replace acc with acc_next (one tail byte consumed)
//   data_byte    current tail byte
//   poly         CRC polynomial
//   reflect_in   reflect data_byte before folding it in
//   acc_next     acc with data_byte folded in (combinational)
module crc_tail_lane
  import crc_pkg::*;
#(
  parameter int CRC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CRC_WIDTH-1:0] load_value,
  input  logic                 step,
  input  logic [7:0]           data_byte,
  input  logic [CRC_WIDTH-1:0] poly,
  input  logic                 reflect_in,
  output logic [CRC_WIDTH-1:0] acc_next
);

  logic [CRC_WIDTH-1:0] acc;

  assign acc_next = CRC_WIDTH'(crc_byte_step(CRC_MAX'(acc), data_byte, CRC_MAX'(poly),
                                             reflect_in, CRC_WIDTH));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_value;
    end else if (step) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/crc_stream_feeder.sv
// Feeds a beat-wide stream into an external CRC engine and finishes frames.
//
// Full beats go straight to the engine (one beat per cycle). A last beat with
// a partial keep mask bypasses the engine: its leading contiguous bytes are
// folded in one per cycle by crc_tail_lane. The result is finalised (output
// reflection, final XOR) and held until the consumer takes it.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   cfg_seed/poly/xor_out            CRC configuration, latched on frame start
//   cfg_reflect_in/out               byte input reflection, output reflection
//   s_valid/s_ready/s_last           input beat handshake, end of frame
//   s_data/s_keep                    beat bytes (byte 0 first), last-beat mask
//   eng_*                            external engine interface
//   eng_crc_out                      engine result, one cycle after enable
//   res_valid/res_ready              result handshake
//   res_crc/res_err                  final CRC, non-contiguous keep flag
module crc_stream_feeder
  import crc_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int CRC_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CRC_WIDTH-1:0]    cfg_seed,
  input  logic [CRC_WIDTH-1:0]    cfg_poly,
  input  logic [CRC_WIDTH-1:0]    cfg_xor_out,
  input  logic                    cfg_reflect_in,
  input  logic                    cfg_reflect_out,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  input  logic [DATA_BYTES*8-1:0] s_data,
  input  logic [DATA_BYTES-1:0]   s_keep,
  output logic [DATA_BYTES*8-1:0] eng_data,
  output logic [CRC_WIDTH-1:0]    eng_crc_in,
  output logic [CRC_WIDTH-1:0]    eng_poly,
  output logic                    eng_enable,
  output logic                    eng_reflect_in,
  output logic                    eng_reflect_out,
  output logic [CRC_WIDTH-1:0]    eng_final_xor,
  input  logic [CRC_WIDTH-1:0]    eng_crc_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [CRC_WIDTH-1:0]    res_crc,
  output logic                    res_err
);

  localparam int KW = $clog2(DATA_BYTES + 1);
  localparam int DW = DATA_BYTES * 8;

  state_t state;

  logic [CRC_WIDTH-1:0] poly_q;
  logic [CRC_WIDTH-1:0] xor_out_q;
  logic                 reflect_in_q;
  logic                 reflect_out_q;

  logic [DW-1:0]        tail_data_q;
  logic [KW-1:0]        tail_k_q;
  logic [KW-1:0]        tail_idx_q;
  logic                 tail_err_q;

  // In IDLE the frame has not latched its configuration yet, so the live
  // inputs are used; from the first accepted beat on, the latched copy is.
  logic                 in_idle;
  logic [CRC_WIDTH-1:0] eff_poly;
  logic [CRC_WIDTH-1:0] eff_xor_out;
  logic                 eff_reflect_in;
  logic                 eff_reflect_out;

  assign in_idle         = (state == IDLE);
  assign eff_poly        = in_idle ? cfg_poly        : poly_q;
  assign eff_xor_out     = in_idle ? cfg_xor_out     : xor_out_q;
  assign eff_reflect_in  = in_idle ? cfg_reflect_in  : reflect_in_q;
  assign eff_reflect_out = in_idle ? cfg_reflect_out : reflect_out_q;

  logic accept;
  logic keep_full;
  logic last_partial;

  assign accept       = s_valid & s_ready;
  assign keep_full    = &s_keep;
  assign last_partial = accept & s_last & ~keep_full;

  // Engine side. Outside IDLE the engine is fed its own output, so on cycles
  // without enable it keeps the running CRC.
  assign eng_data        = s_data;
  assign eng_crc_in      = in_idle ? cfg_seed : eng_crc_out;
  assign eng_poly        = eff_poly;
  assign eng_reflect_in  = eff_reflect_in;
  assign eng_enable      = accept & (~s_last | keep_full);
  assign eng_reflect_out = 1'b0;
  assign eng_final_xor   = '0;

  // Last-beat keep analysis: keep_cnt counts the contiguous ones from bit 0,
  // keep_err flags any set bit beyond the first zero.
  logic [KW-1:0] keep_cnt;
  logic          keep_err;
  logic          zero_seen;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    keep_cnt  = '0;
    keep_err  = 1'b0;
    zero_seen = 1'b0;
    for (int j = 0; j < DATA_BYTES; j++) begin
      if (!s_keep[j])     zero_seen = 1'b1;
      else if (zero_seen) keep_err  = 1'b1;
      else                keep_cnt  = keep_cnt + KW'(1);
    end
  end

  // Tail lane.
  logic                 tail_step;
  logic [7:0]           tail_byte;
  logic [CRC_WIDTH-1:0] tail_next;
  logic                 tail_done;

  assign tail_step = (state == TAIL);
  assign tail_byte = tail_data_q[{tail_idx_q, 3'b000} +: 8];
  assign tail_done = (tail_idx_q == tail_k_q - KW'(1));

  crc_tail_lane #(
    .CRC_WIDTH (CRC_WIDTH)
  ) u_tail (
    .clk        (clk),
    .rst        (rst),
    .load       (last_partial),
    .load_value (eng_crc_in),
    .step       (tail_step),
    .data_byte  (tail_byte),
    .poly       (eff_poly),
    .reflect_in (eff_reflect_in),
    .acc_next   (tail_next)
  );

  // Value to finalise when entering RESULT: the engine result after FLUSH,
  // the last tail step, or (k = 0) the running CRC the lane is loaded with.
  logic [CRC_WIDTH-1:0] fin_src;
  logic [CRC_WIDTH-1:0] fin_crc;

  always_comb begin
    fin_src = eng_crc_in;
    case (state)
      FLUSH:   fin_src = eng_crc_out;
      TAIL:    fin_src = tail_next;
      default: fin_src = eng_crc_in;
    endcase
    fin_crc = CRC_WIDTH'(crc_finalize(CRC_MAX'(fin_src), eff_reflect_out,
                                      CRC_MAX'(eff_xor_out), CRC_WIDTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      s_ready       <= 1'b1;
      res_valid     <= 1'b0;
      res_crc       <= '0;
      res_err       <= 1'b0;
      poly_q        <= '0;
      xor_out_q     <= '0;
      reflect_in_q  <= 1'b0;
      reflect_out_q <= 1'b0;
      // NOTE: the tail beat buffer is a plain register, not a RAM, so it is
      // cleared with everything else.
      tail_data_q   <= '0;
      tail_k_q      <= '0;
      tail_idx_q    <= '0;
      tail_err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (accept) begin
            if (in_idle) begin
              poly_q        <= cfg_poly;
              xor_out_q     <= cfg_xor_out;
              reflect_in_q  <= cfg_reflect_in;
              reflect_out_q <= cfg_reflect_out;
            end
            if (!s_last) begin
              state <= RUN;
            end else if (keep_full) begin
              state   <= FLUSH;
              s_ready <= 1'b0;
            end else begin
              s_ready     <= 1'b0;
              tail_data_q <= s_data;
              tail_k_q    <= keep_cnt;
              tail_idx_q  <= '0;
              tail_err_q  <= keep_err;
              if (keep_cnt == '0) begin
                state     <= RESULT;
                res_valid <= 1'b1;
                res_crc   <= fin_crc;
                res_err   <= keep_err;
              end else begin
                state <= TAIL;
              end
            end
          end
        end

        FLUSH: begin
          state     <= RESULT;
          res_valid <= 1'b1;
          res_crc   <= fin_crc;
          res_err   <= 1'b0;
        end

        TAIL: begin
          tail_idx_q <= tail_idx_q + KW'(1);
          if (tail_done) begin
            state     <= RESULT;
            res_valid <= 1'b1;
            res_crc   <= fin_crc;
            res_err   <= tail_err_q;
          end
        end

        RESULT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            s_ready   <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          s_ready   <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_stream_feeder.sv
// Self-checking bench for crc_stream_feeder (DATA_BYTES = 8, CRC_WIDTH = 32).
// Holds a behavioural model of the external engine and a bit-serial CRC
// reference, applies a table of directed frames, a reset-during-tail
// sequence, and randomized frames with bubbles and config scrambling.
module tb_crc_stream_feeder;

  localparam int K_ASCII = 0;
  localparam int K_RAMP  = 1;
  localparam int K_RAND  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_seed, cfg_poly, cfg_xor_out;
  logic        cfg_reflect_in, cfg_reflect_out;
  logic        s_valid, s_last, s_ready;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic [63:0] eng_data;
  logic [31:0] eng_crc_in, eng_poly, eng_final_xor, eng_crc_out;
  logic        eng_enable, eng_reflect_in, eng_reflect_out;
  logic        res_valid, res_ready, res_err;
  logic [31:0] res_crc;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  crc_stream_feeder #(
    .DATA_BYTES (8),
    .CRC_WIDTH  (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_seed        (cfg_seed),
    .cfg_poly        (cfg_poly),
    .cfg_xor_out     (cfg_xor_out),
    .cfg_reflect_in  (cfg_reflect_in),
    .cfg_reflect_out (cfg_reflect_out),
    .s_valid         (s_valid),
    .s_last          (s_last),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .s_keep          (s_keep),
    .eng_data        (eng_data),
    .eng_crc_in      (eng_crc_in),
    .eng_poly        (eng_poly),
    .eng_enable      (eng_enable),
    .eng_reflect_in  (eng_reflect_in),
    .eng_reflect_out (eng_reflect_out),
    .eng_final_xor   (eng_final_xor),
    .eng_crc_out     (eng_crc_out),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_crc         (res_crc),
    .res_err         (res_err)
  );

  // Bit-serial CRC: each message bit (LSB-first if reflected) is compared
  // with the register MSB and the polynomial applied on a difference.
  function automatic logic [31:0] crc_bits(input logic [31:0] crc, input logic [7:0] b,
                                           input logic [31:0] poly, input bit refin);
    bit in_bit, fb;
    for (int i = 0; i < 8; i++) begin
      in_bit = refin ? b[i] : b[7-i];
      fb     = crc[31] ^ in_bit;
      crc    = {crc[30:0], 1'b0};
      if (fb) crc = crc ^ poly;
    end
    return crc;
  endfunction

  // External engine: registered, all eight bytes, holds when not enabled.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_crc_out <= '0;
    end else if (eng_enable) begin
      logic [31:0] c;
      c = eng_crc_in;
      for (int j = 0; j < 8; j++) c = crc_bits(c, eng_data[8*j +: 8], eng_poly, eng_reflect_in);
      eng_crc_out <= c;
    end
  end

  typedef struct {
    string       name;
    int          nbeats;
    logic [7:0]  keep_last;
    int          kind;
    logic [31:0] seed, poly, xorout;
    bit          refin, refout;
    int          hold;
    bit          crc_known;
    logic [31:0] exp_crc;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  function automatic logic [31:0] ref_frame(input logic [7:0] q[$], input vec_t v);
    logic [31:0] c;
    c = v.seed;
    foreach (q[i]) c = crc_bits(c, q[i], v.poly, v.refin);
    if (v.refout) c = {<<{c}};
    return c ^ v.xorout;
  endfunction

  function automatic int lat_of(input logic [7:0] keep);
    int k;
    if (keep == 8'hFF) return 2;
    k = 0;
    while (k < 8 && keep[k]) k++;
    return k + 1;
  endfunction

  function automatic bit err_of(input logic [7:0] keep);
    int k;
    k = 0;
    while (k < 8 && keep[k]) k++;
    return (k < 8) && ((keep >> k) != 8'h00);
  endfunction

  function automatic vec_t mk(input string name, input int nbeats, input logic [7:0] keep,
                              input int kind, input bit mpeg, input int hold,
                              input bit known, input logic [31:0] crc,
                              input bit err, input int lat);
    vec_t v;
    v.name = name; v.nbeats = nbeats; v.keep_last = keep; v.kind = kind;
    v.seed = 32'hFFFF_FFFF; v.poly = 32'h04C1_1DB7;
    v.refin = !mpeg; v.refout = !mpeg; v.xorout = mpeg ? 32'h0 : 32'hFFFF_FFFF;
    v.hold = hold; v.crc_known = known; v.exp_crc = crc; v.exp_err = err; v.exp_lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_cfg(input vec_t v);
    cfg_seed = v.seed; cfg_poly = v.poly; cfg_xor_out = v.xorout;
    cfg_reflect_in = v.refin; cfg_reflect_out = v.refout;
  endtask

  task automatic run_frame(input vec_t v, input bit bubbles, input bit scramble);
    logic [7:0]  covered[$];
    logic [63:0] data;
    logic [7:0]  keep;
    logic [31:0] exp_crc;
    bit          last, zero_seen, got_valid;
    int          lat;
    set_cfg(v);
    for (int b = 0; b < v.nbeats; b++) begin
      last = (b == v.nbeats - 1);
      for (int j = 0; j < 8; j++) begin
        case (v.kind)
          K_ASCII: data[8*j +: 8] = 8'(8'h31 + b*8 + j);
          K_RAMP:  data[8*j +: 8] = 8'(b*8 + j);
          default: data[8*j +: 8] = 8'($urandom);
        endcase
      end
      keep = last ? v.keep_last : 8'($urandom);
      zero_seen = 1'b0;
      for (int j = 0; j < 8; j++) begin
        if (last && !keep[j]) zero_seen = 1'b1;
        if (!zero_seen) covered.push_back(data[8*j +: 8]);
      end
      if (bubbles && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        @(negedge clk);
        check("s_ready_bubble", s_ready, 1);
      end
      @(negedge clk);
      s_valid = 1'b1; s_last = last; s_data = data; s_keep = keep;
      #1;
      check("s_ready_accept", s_ready, 1);
      check("eng_enable", eng_enable, (!last || keep == 8'hFF));
      if (b == 0) begin
        check("eng_crc_in_seed", eng_crc_in, v.seed);
        check("eng_poly_live", eng_poly, v.poly);
      end else begin
        check("eng_poly_latched", eng_poly, v.poly);
        check("eng_refin_latched", eng_reflect_in, v.refin);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0; s_last = 1'b0; s_keep = '0; s_data = {$urandom, $urandom};
      if (scramble && b == 0) begin
        cfg_seed = $urandom; cfg_poly = $urandom; cfg_xor_out = $urandom;
        cfg_reflect_in = ~v.refin; cfg_reflect_out = ~v.refout;
      end
    end
    exp_crc = v.crc_known ? v.exp_crc : ref_frame(covered, v);

    lat = 0;
    got_valid = 1'b0;
    while (!got_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (res_valid) got_valid = 1'b1;
      else begin
        check("s_ready_busy", s_ready, 0);
        check("eng_enable_busy", eng_enable, 0);
      end
    end
    check({v.name, "_res_valid"}, got_valid, 1);
    check({v.name, "_latency"}, lat, v.exp_lat);
    check({v.name, "_res_crc"}, res_crc, exp_crc);
    check({v.name, "_res_err"}, res_err, v.exp_err);
    check("s_ready_result", s_ready, 0);

    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check("hold_res_valid", res_valid, 1);
      check("hold_res_crc", res_crc, exp_crc);
      check("hold_res_err", res_err, v.exp_err);
      check("hold_s_ready", s_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("after_hs_res_valid", res_valid, 0);
    check("after_hs_s_ready", s_ready, 1);
  endtask

  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [7:0] rk;

    tbl[0] = mk("crc32_check", 2, 8'h01, K_ASCII, 0, 0, 1, 32'hCBF4_3926, 0, 2);
    tbl[1] = mk("mpeg2",       2, 8'h01, K_ASCII, 1, 0, 1, 32'h0376_E6E7, 0, 2);
    tbl[2] = mk("ramp16",      2, 8'hFF, K_RAMP,  0, 0, 0, 32'h0,         0, 2);
    tbl[3] = mk("hold5",       2, 8'h01, K_ASCII, 0, 5, 1, 32'hCBF4_3926, 0, 2);
    tbl[4] = mk("keep05",      2, 8'h05, K_ASCII, 0, 1, 1, 32'hCBF4_3926, 1, 2);
    tbl[5] = mk("keep00",      2, 8'h00, K_ASCII, 0, 0, 0, 32'h0,         0, 1);
    tbl[6] = mk("keep0f",      1, 8'h0F, K_RAND,  1, 0, 0, 32'h0,         0, 5);
    tbl[7] = mk("keepf0",      1, 8'hF0, K_RAND,  0, 2, 0, 32'h0,         1, 1);
    tbl[8] = mk("keep7f",      3, 8'h7F, K_RAND,  0, 0, 0, 32'h0,         0, 8);
    tbl[9] = mk("full_single", 1, 8'hFF, K_RAND,  1, 0, 0, 32'h0,         0, 2);

    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_keep = '0; res_ready = 1'b0;
    set_cfg(tbl[0]);
    repeat (3) @(negedge clk);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_crc", res_crc, 0);
    check("rst_res_err", res_err, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_eng_enable", eng_enable, 0);
    rst = 1'b0;
    @(negedge clk);
    check("eng_reflect_out_tied", eng_reflect_out, 0);
    check("eng_final_xor_tied", eng_final_xor, 0);
    check("idle_eng_crc_in", eng_crc_in, 32'hFFFF_FFFF);

    for (int i = 0; i < 10; i++) run_frame(tbl[i], 1'b0, 1'b1);

    // Reset while the tail lane is working discards the frame.
    set_cfg(tbl[0]);
    @(negedge clk);
    s_valid = 1'b1; s_last = 1'b1; s_keep = 8'h7F; s_data = {$urandom, $urandom};
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0; s_keep = '0;
    @(negedge clk);
    check("tail_s_ready", s_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("tail_rst_res_valid", res_valid, 0);
    check("tail_rst_s_ready", s_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_res_valid", res_valid, 0);
    end
    check("post_rst_s_ready", s_ready, 1);
    run_frame(tbl[0], 1'b0, 1'b0);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       rk = 8'hFF;
        1:       rk = 8'((9'h1 << $urandom_range(0, 7)) - 9'h1);
        default: rk = 8'($urandom);
      endcase
      v = mk("rand", $urandom_range(1, 3), rk, K_RAND, 0, $urandom_range(0, 3), 0, 32'h0,
             err_of(rk), lat_of(rk));
      v.seed = $urandom; v.poly = $urandom | 32'h1; v.xorout = $urandom;
      v.refin = 1'($urandom); v.refout = 1'($urandom);
      run_frame(v, 1'b1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
